// File: rtl/regbus_pkg.sv
// Shared definitions for the register-transfer sequencer: word width,
// transaction encodings and FSM state enumeration.
package regbus_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'd0,
        OP_LOADI = 2'd1,
        OP_READ  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/sel_decode.sv
// Index-to-one-hot strobe decoder; indices at or beyond NREG decode to zero.
module sel_decode #(
    parameter int NREG = 8,
    parameter int SW   = 5
) (
    input  logic [SW-1:0]   idx_i,
    input  logic            en_i,
    output logic [NREG-1:0] vec_o
);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            assign vec_o[gi] = en_i && (idx_i == SW'(gi));
        end
    endgenerate

endmodule

// File: rtl/regbus_xfer.sv
// Multicycle register-transfer sequencer: drives per-register read/write
// strobes and the shared write bus for MOVE, LOADI and READ transactions.
module regbus_xfer
    import regbus_pkg::*;
#(
    parameter int NREG = 8,
    parameter int SW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [SW-1:0]     src_sel,
    input  logic [SW-1:0]     dst_sel,
    input  logic [WORD_W-1:0] imm,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WORD_W-1:0] rdata_out,
    output logic [NREG-1:0]   rd_en,
    output logic [NREG-1:0]   wr_en,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [SW-1:0]       src_q, src_d;
    logic [SW-1:0]       dst_q, dst_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic                err_q, err_d;

    logic                src_ok, dst_ok, req_ok;

    assign src_ok = 32'(src_sel) < 32'(NREG);
    assign dst_ok = 32'(dst_sel) < 32'(NREG);

    // Only the indices actually used by the requested op are range-checked.
    always_comb begin
        req_ok = 1'b0;
        case (op_e'(op))
            OP_MOVE:  req_ok = src_ok && dst_ok;
            OP_LOADI: req_ok = dst_ok;
            OP_READ:  req_ok = src_ok;
            default:  req_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MOVE;
            src_q   <= '0;
            dst_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        hold_d  = hold_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d  = op_e'(op);
                    src_d = src_sel;
                    dst_d = dst_sel;
                    err_d = !req_ok;
                    if (!req_ok) begin
                        state_d = S_DONE;
                    end else if (op_e'(op) == OP_LOADI) begin
                        hold_d  = imm;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = S_CAP;
            S_CAP: begin
                hold_d  = bus_rdata;
                state_d = (op_q == OP_MOVE) ? S_WR : S_DONE;
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = done && err_q;
    assign rdata_out = hold_q;
    // The write bus always carries hold; only the strobe marks it as live.
    assign bus_wdata = hold_q;

    sel_decode #(.NREG(NREG), .SW(SW)) u_rd_decode (
        .idx_i (src_q),
        .en_i  ((state_q == S_RD) || (state_q == S_CAP)),
        .vec_o (rd_en)
    );

    sel_decode #(.NREG(NREG), .SW(SW)) u_wr_decode (
        .idx_i (dst_q),
        .en_i  (state_q == S_WR),
        .vec_o (wr_en)
    );

endmodule

// File: tb/tb_regbus_xfer.sv
// Randomized scoreboard bench for regbus_xfer with an attached register file
// and a transaction-level reference model.
module tb_regbus_xfer;

    localparam int NREG = 8;
    localparam int SW   = 5;
    localparam logic [1:0] K_MOVE  = 2'd0;
    localparam logic [1:0] K_LOADI = 2'd1;
    localparam logic [1:0] K_READ  = 2'd2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req;
    logic [1:0]      op;
    logic [SW-1:0]   src_sel, dst_sel;
    logic [31:0]     imm;
    logic            busy, done, err;
    logic [31:0]     rdata_out, bus_wdata, bus_rdata;
    logic [NREG-1:0] rd_en, wr_en;

    regbus_xfer #(.NREG(NREG), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .imm       (imm),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata_out (rdata_out),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached registers: answer read strobes, absorb write strobes.
    logic [31:0] phys [NREG];
    logic [31:0] model_regs [NREG];
    logic [31:0] pre_regs [NREG];
    logic        load_init;
    logic [31:0] junk;

    always @(posedge clk) begin
        if (load_init) begin
            for (int i = 0; i < NREG; i++) phys[i] <= model_regs[i];
        end else if (!rst) begin
            for (int i = 0; i < NREG; i++) if (wr_en[i]) phys[i] <= bus_wdata;
        end
    end

    always_comb begin
        bus_rdata = junk;
        for (int i = 0; i < NREG; i++) if (rd_en[i]) bus_rdata = phys[i];
    end

    typedef struct {
        int          acc;
        int          lat;
        bit          rd;
        int          src;
        bit          wr;
        int          dst;
        logic [31:0] wval;
        bit          err;
        logic [31:0] rdata;
    } item_t;

    item_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int free_cyc = 0;
    logic [31:0] model_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: outcome of one accepted transaction at the transaction level.
    task automatic model_accept(input logic [1:0] o, input int s, input int d, input logic [31:0] im);
        item_t t;
        bit bad;
        bad = (o == 2'd3)
            || ((o == K_MOVE || o == K_READ) && s >= NREG)
            || ((o == K_MOVE || o == K_LOADI) && d >= NREG);
        pre_regs = model_regs;
        t.acc = cyc; t.rd = 0; t.wr = 0; t.src = s; t.dst = d; t.wval = '0; t.err = bad;
        if (bad) begin
            t.lat = 1;
        end else if (o == K_MOVE) begin
            t.lat = 4; t.rd = 1; t.wr = 1;
            t.wval = model_regs[s];
            model_hold = t.wval;
            model_regs[d] = t.wval;
        end else if (o == K_READ) begin
            t.lat = 3; t.rd = 1;
            model_hold = model_regs[s];
        end else begin
            t.lat = 2; t.wr = 1;
            t.wval = im;
            model_hold = im;
            model_regs[d] = im;
        end
        t.rdata = model_hold;
        free_cyc = cyc + t.lat + 1;
        q.push_back(t);
    endtask

    task automatic cycle_in(input bit r, input logic [1:0] o, input int s, input int d, input logic [31:0] im);
        req = r; op = o; src_sel = SW'(s); dst_sel = SW'(d); imm = im;
        junk = $urandom;
        if (r && cyc >= free_cyc) model_accept(o, s, d, im);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_in(0, 2'd0, 0, 0, 32'h0);
    endtask

    task automatic step_rand(input bit r);
        cycle_in(r, 2'($urandom_range(0, 3)), $urandom_range(0, 9), $urandom_range(0, 9), $urandom);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rd_en", 32'(rd_en), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_rdata_out", rdata_out, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
    endtask

    // Monitor: per-cycle expectations derived from the in-flight transaction.
    item_t           mt;
    int              rel;
    logic [NREG-1:0] exp_rd, exp_wr;
    logic [31:0]     last_rdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                last_rdata = '0;
            end else if (q.size() == 0) begin
                check("idle_busy", 32'(busy), 32'h0);
                check("idle_done", 32'(done), 32'h0);
                check("idle_rd_en", 32'(rd_en), 32'h0);
                check("idle_wr_en", 32'(wr_en), 32'h0);
                check("idle_rdata_out", rdata_out, last_rdata);
                check("idle_bus_wdata", bus_wdata, last_rdata);
            end else begin
                mt = q[0];
                rel = cyc - mt.acc;
                exp_rd = '0;
                exp_wr = '0;
                if (mt.rd && (rel == 1 || rel == 2)) exp_rd[mt.src] = 1'b1;
                if (mt.wr && rel == mt.lat - 1) exp_wr[mt.dst] = 1'b1;
                check("busy", 32'(busy), 32'(rel >= 1 && rel <= mt.lat));
                check("done", 32'(done), 32'(rel == mt.lat));
                check("rd_en", 32'(rd_en), 32'(exp_rd));
                check("wr_en", 32'(wr_en), 32'(exp_wr));
                if (exp_wr != '0) check("bus_wdata", bus_wdata, mt.wval);
                if (rel >= mt.lat) begin
                    check("err", 32'(err), 32'(mt.err));
                    check("rdata_out", rdata_out, mt.rdata);
                    for (int i = 0; i < NREG; i++) check("regfile", phys[i], model_regs[i]);
                    last_rdata = mt.rdata;
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; op = '0; src_sel = '0; dst_sel = '0; imm = '0;
        load_init = 1'b0; junk = '0; model_hold = '0;
        for (int i = 0; i < NREG; i++) model_regs[i] = $urandom;
        model_regs[2] = 32'hDEAD_BEEF;
        model_regs[7] = 32'h1234_5678;
        load_init = 1'b1;
        @(posedge clk); #1;
        load_init = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        rst = 1'b0;
        free_cyc = cyc;
        idle(2);

        cycle_in(1, K_MOVE, 2, 5, 32'h0);           idle(6);
        cycle_in(1, K_LOADI, 3, 0, 32'h0040_0000);  idle(5);
        cycle_in(1, K_READ, 7, 0, 32'h0);           idle(8);
        cycle_in(1, K_MOVE, 9, 1, 32'h0);           idle(3);
        cycle_in(1, 2'd3, 1, 1, 32'h0);             idle(3);
        cycle_in(1, K_MOVE, 4, 4, 32'h0);           idle(6);

        // Reset two cycles into a MOVE: the write must never land.
        cycle_in(1, K_MOVE, 1, 3, 32'h0);
        rst = 1'b1;
        model_regs = pre_regs;
        model_hold = '0;
        idle(1);
        check_reset_outputs();
        idle(1);
        rst = 1'b0;
        free_cyc = cyc;
        idle(6);

        repeat (300) step_rand($urandom_range(0, 2) == 0);
        repeat (200) step_rand(1'b1);
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
